// File: rtl/rv32_clint_pkg.sv
// Shared constants for the CLINT machine-timer / software-interrupt block.
//   CLINT_*        : word offsets of the register port (addr_i)
//   MTIMECMP_RST   : default reset value of mtimecmp (max value, so no MTIP out of reset)
package rv32_clint_pkg;

    localparam logic [2:0] CLINT_MSIP        = 3'd0;
    localparam logic [2:0] CLINT_MTIMECMP_LO = 3'd1;
    localparam logic [2:0] CLINT_MTIMECMP_HI = 3'd2;
    localparam logic [2:0] CLINT_MTIME_LO    = 3'd3;
    localparam logic [2:0] CLINT_MTIME_HI    = 3'd4;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/rv32_edge_detect.sv
// Registered previous-value rising-edge detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   level_i    : level input, already synchronous to clk
//   rise_o     : high for the cycle in which level_i is 1 and was 0 the cycle before
module rv32_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic rise_o
);

    logic level_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level_i;
        end
    end

    assign rise_o = level_i & ~level_prev;

endmodule

// File: rtl/rv32_clint_timer.sv
// CLINT machine timer and software interrupt core.
// Counts prescaled rising edges of the synchronized RTC tick into the 64-bit
// mtime, raises MTIP when mtime >= mtimecmp and holds MSIP, all accessible
// through a single-cycle register port.
//   clk, rst_n           : clock, asynchronous active-low reset
//   rtc_tick_i           : synchronized RTC tick level (rising edges count)
//   req_i/we_i/addr_i/wdata_i : register request (one-cycle pulse per access)
//   rvalid_o/rdata_o/err_o    : response, one cycle after each request
//   mtip_o, msip_o       : registered interrupt-pending outputs
module rv32_clint_timer #(
    parameter int unsigned TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = rv32_clint_pkg::MTIMECMP_RST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rtc_tick_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        mtip_o,
    output logic        msip_o
);

    import rv32_clint_pkg::*;

    localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);

    logic        tick_rise;
    logic [7:0]  prescaler;
    logic        mtime_inc_en;
    logic [63:0] mtime_q;
    logic [63:0] mtime_inc;
    logic [63:0] mtimecmp_q;
    logic        msip_q;
    logic        wr_en;
    logic        addr_err;
    logic [31:0] rd_word;

    rv32_edge_detect u_tick_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (rtc_tick_i),
        .rise_o  (tick_rise)
    );

    assign mtime_inc_en = tick_rise && (prescaler == DIV_LAST);
    assign mtime_inc    = mtime_q + 64'd1;
    assign wr_en        = req_i & we_i;
    assign addr_err     = addr_i > CLINT_MTIME_HI;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick_rise) begin
            prescaler <= (prescaler == DIV_LAST) ? '0 : prescaler + 8'd1;
        end
    end

    // Each half independently takes either the software write or its slice of
    // the incremented value. A write to the low half therefore still lets the
    // high half take a carry out of the low half, while a write to a half
    // discards that half's share of the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q <= '0;
        end else begin
            if (wr_en && addr_i == CLINT_MTIME_LO) begin
                mtime_q[31:0] <= wdata_i;
            end else if (mtime_inc_en) begin
                mtime_q[31:0] <= mtime_inc[31:0];
            end
            if (wr_en && addr_i == CLINT_MTIME_HI) begin
                mtime_q[63:32] <= wdata_i;
            end else if (mtime_inc_en) begin
                mtime_q[63:32] <= mtime_inc[63:32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
        end else if (wr_en) begin
            case (addr_i)
                CLINT_MSIP:        msip_q            <= wdata_i[0];
                CLINT_MTIMECMP_LO: mtimecmp_q[31:0]  <= wdata_i;
                CLINT_MTIMECMP_HI: mtimecmp_q[63:32] <= wdata_i;
                default:           ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtip_o <= 1'b0;
        end else begin
            mtip_o <= (mtime_q >= mtimecmp_q);
        end
    end

    assign msip_o = msip_q;

    always_comb begin
        rd_word = '0;
        case (addr_i)
            CLINT_MSIP:        rd_word = {31'b0, msip_q};
            CLINT_MTIMECMP_LO: rd_word = mtimecmp_q[31:0];
            CLINT_MTIMECMP_HI: rd_word = mtimecmp_q[63:32];
            CLINT_MTIME_LO:    rd_word = mtime_q[31:0];
            CLINT_MTIME_HI:    rd_word = mtime_q[63:32];
            default:           rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= req_i;
            err_o    <= req_i & addr_err;
            rdata_o  <= (req_i && !we_i && !addr_err) ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_rv32_clint_timer.sv
module tb_rv32_clint_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        tick4;
    logic        req;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;

    logic        rvalid, err, mtip, msip;
    logic [31:0] rdata;
    logic        rvalid4, err4, mtip4, msip4;
    logic [31:0] rdata4;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    rv32_clint_timer #(.TICK_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .rtc_tick_i(tick),
        .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .mtip_o(mtip), .msip_o(msip)
    );

    rv32_clint_timer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .rtc_tick_i(tick4),
        .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rvalid_o(rvalid4), .rdata_o(rdata4), .err_o(err4),
        .mtip_o(mtip4), .msip_o(msip4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read: request in one cycle, response sampled 1 time unit after the next edge.
    task automatic rd(input logic [2:0] a);
        req = 1'b1; we = 1'b0; addr = a; wdata = '0;
        step();
        req = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        step();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rise1();
        tick = 1'b1; step();
        tick = 1'b0; step();
    endtask

    task automatic rise4();
        tick4 = 1'b1; step();
        tick4 = 1'b0; step();
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; tick4 = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_mtip", {31'b0, mtip}, 32'd0);
        chk("rst_msip", {31'b0, msip}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        rd(3'd3);
        chk("rst_rd_mtime_lo_valid", {31'b0, rvalid}, 32'd1);
        chk("rst_rd_mtime_lo", rdata, 32'd0);
        chk("rst_rd_mtime_lo_err", {31'b0, err}, 32'd0);
        step();
        chk("rvalid_single_pulse", {31'b0, rvalid}, 32'd0);
        rd(3'd2);
        chk("rst_rd_mtimecmp_hi", rdata, 32'hFFFF_FFFF);
        rd(3'd1);
        chk("rst_rd_mtimecmp_lo", rdata, 32'hFFFF_FFFF);

        // TICK_DIV=4: 9 rises -> 2, two more -> still 2, one more -> 3
        repeat (9) rise4();
        rd(3'd3);
        chk("div4_after9", rdata4, 32'd2);
        repeat (2) rise4();
        rd(3'd3);
        chk("div4_after11", rdata4, 32'd2);
        rise4();
        rd(3'd3);
        chk("div4_after12", rdata4, 32'd3);
        rd(3'd3);
        chk("div1_untouched", rdata, 32'd0);

        // Long-held tick counts once per rise
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1; repeat (10) step();
            tick = 1'b0; repeat (2) step();
        end
        rd(3'd3);
        chk("held_tick_lo", rdata, 32'd5);
        rd(3'd4);
        chk("held_tick_hi", rdata, 32'd0);

        // MTIP
        wr(3'd3, 32'd0);
        chk("wr_resp_rdata", rdata, 32'd0);
        chk("wr_resp_valid", {31'b0, rvalid}, 32'd1);
        wr(3'd2, 32'd0);
        wr(3'd1, 32'd3);
        step();
        chk("mtip_cmp3_idle", {31'b0, mtip}, 32'd0);
        rise1();
        rise1();
        chk("mtip_at2", {31'b0, mtip}, 32'd0);
        tick = 1'b1; step();
        chk("mtip_lag", {31'b0, mtip}, 32'd0);
        tick = 1'b0; step();
        chk("mtip_at3", {31'b0, mtip}, 32'd1);
        wr(3'd1, 32'd10);
        chk("mtip_hold_on_wr", {31'b0, mtip}, 32'd1);
        step();
        chk("mtip_clear", {31'b0, mtip}, 32'd0);

        // Carry into high half
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd4, 32'd0);
        rise1();
        rd(3'd3);
        chk("carry_lo", rdata, 32'd0);
        rd(3'd4);
        chk("carry_hi", rdata, 32'd1);

        // Write lo in the same cycle as an increment: write wins, hi unchanged
        tick = 1'b1;
        req = 1'b1; we = 1'b1; addr = 3'd3; wdata = 32'h0000_1234;
        step();
        tick = 1'b0; req = 1'b0; we = 1'b0;
        step();
        rd(3'd3);
        chk("wr_vs_inc_lo", rdata, 32'h0000_1234);
        rd(3'd4);
        chk("wr_vs_inc_hi", rdata, 32'd1);

        // Write lo in the same cycle as an increment that carries: hi takes carry
        wr(3'd3, 32'hFFFF_FFFF);
        tick = 1'b1;
        req = 1'b1; we = 1'b1; addr = 3'd3; wdata = 32'h0000_0055;
        step();
        tick = 1'b0; req = 1'b0; we = 1'b0;
        step();
        rd(3'd3);
        chk("wr_carry_lo", rdata, 32'h0000_0055);
        rd(3'd4);
        chk("wr_carry_hi", rdata, 32'd2);

        // 64-bit wrap
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd4, 32'hFFFF_FFFF);
        rise1();
        rd(3'd3);
        chk("wrap_lo", rdata, 32'd0);
        rd(3'd4);
        chk("wrap_hi", rdata, 32'd0);

        // MSIP
        wr(3'd0, 32'h0000_0001);
        chk("msip_set", {31'b0, msip}, 32'd1);
        rd(3'd0);
        chk("msip_read", rdata, 32'd1);

        // Unmapped address
        rd(3'd6);
        chk("err_flag", {31'b0, err}, 32'd1);
        chk("err_rdata", rdata, 32'd0);
        chk("err_valid", {31'b0, rvalid}, 32'd1);
        rd(3'd1);
        chk("err_no_change", rdata, 32'd10);

        // Force MTIP high (mtime 0 >= cmp 0), then reset mid-read
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd0);
        step();
        chk("mtip_pre_rst", {31'b0, mtip}, 32'd1);
        req = 1'b1; we = 1'b0; addr = 3'd2;
        #3 rst_n = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        chk("rst_drop_valid", {31'b0, rvalid}, 32'd0);
        chk("rst_drop_rdata", rdata, 32'd0);
        chk("rst_mtip_clr", {31'b0, mtip}, 32'd0);
        chk("rst_msip_clr", {31'b0, msip}, 32'd0);
        #3 rst_n = 1'b1;
        step();
        rd(3'd1);
        chk("rst2_cmp_lo", rdata, 32'hFFFF_FFFF);
        rd(3'd2);
        chk("rst2_cmp_hi", rdata, 32'hFFFF_FFFF);
        rd(3'd0);
        chk("rst2_msip", rdata, 32'd0);
        rd(3'd3);
        chk("rst2_mtime_lo", rdata, 32'd0);
        chk("rst2_div4_mtime_lo", rdata4, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
